// File: rtl/hazard_ctrl.sv
// hazard_ctrl: load-use and HI/LO-unit hazard detection, branch flush control and saturating stall counter
module hazard_ctrl #(
    parameter int MUL_LAT = 4,
    parameter int DIV_LAT = 32
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [4:0]  ID_regRs,
    input  logic [4:0]  ID_regRt,
    input  logic        ID_usesRt,
    input  logic [4:0]  ID_EX_regRt,
    input  logic        ID_EX_memRead,
    input  logic        ID_isMulDiv,
    input  logic        ID_isDiv,
    input  logic        ID_readsHiLo,
    input  logic        EX_branchTaken,
    output logic        pcWrite,
    output logic        IF_ID_write,
    output logic        IF_ID_flush,
    output logic        ID_EX_flush,
    output logic        md_start,
    output logic        md_busy,
    output logic        md_done,
    output logic [15:0] stall_cycles
);
    logic [5:0]  md_cnt_q, md_cnt_d;
    logic [15:0] stall_q, stall_d;
    logic        lu, mh, st;
    assign md_busy      = md_cnt_q != 6'd0;
    assign md_done      = md_cnt_q == 6'd1;
    assign stall_cycles = stall_q;
    always_comb begin
        lu          = ID_EX_memRead && ID_EX_regRt != 5'd0 &&
                      (ID_EX_regRt == ID_regRs || (ID_usesRt && ID_EX_regRt == ID_regRt));
        mh          = md_busy && (ID_isMulDiv || ID_readsHiLo);
        st          = (lu || mh) && !EX_branchTaken;
        pcWrite     = !st;
        IF_ID_write = !st;
        IF_ID_flush = EX_branchTaken;
        ID_EX_flush = st || EX_branchTaken;
        md_start    = ID_isMulDiv && !st && !EX_branchTaken;
        md_cnt_d    = md_start ? (ID_isDiv ? 6'(DIV_LAT) : 6'(MUL_LAT))
                               : (md_busy ? md_cnt_q - 6'd1 : md_cnt_q);
        stall_d     = (st && stall_q != 16'hFFFF) ? stall_q + 16'd1 : stall_q;
    end
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            md_cnt_q <= 6'd0;
            stall_q  <= 16'd0;
        end else begin
            md_cnt_q <= md_cnt_d;
            stall_q  <= stall_d;
        end
    end
endmodule

// File: tb/tb_hazard_ctrl.sv
// tb_hazard_ctrl: table vectors plus hand sequences, scoreboarded against hazard_ctrl outputs
module tb_hazard_ctrl;
    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [4:0]  ID_regRs, ID_regRt, ID_EX_regRt;
    logic        ID_usesRt, ID_EX_memRead, ID_isMulDiv, ID_isDiv, ID_readsHiLo, EX_branchTaken;
    logic        pcWrite, IF_ID_write, IF_ID_flush, ID_EX_flush, md_start, md_busy, md_done;
    logic [15:0] stall_cycles;

    hazard_ctrl #(.MUL_LAT(4), .DIV_LAT(32)) dut (
        .clk(clk), .rst_n(rst_n),
        .ID_regRs(ID_regRs), .ID_regRt(ID_regRt), .ID_usesRt(ID_usesRt),
        .ID_EX_regRt(ID_EX_regRt), .ID_EX_memRead(ID_EX_memRead),
        .ID_isMulDiv(ID_isMulDiv), .ID_isDiv(ID_isDiv), .ID_readsHiLo(ID_readsHiLo),
        .EX_branchTaken(EX_branchTaken),
        .pcWrite(pcWrite), .IF_ID_write(IF_ID_write), .IF_ID_flush(IF_ID_flush),
        .ID_EX_flush(ID_EX_flush), .md_start(md_start), .md_busy(md_busy),
        .md_done(md_done), .stall_cycles(stall_cycles)
    );

    always #5 clk = ~clk;

    // exp bits: {pcWrite, IF_ID_write, IF_ID_flush, ID_EX_flush, md_start, md_busy, md_done}
    typedef struct {
        logic [4:0] rs, rt, ex_rt;
        logic       uses_rt, mem_rd, md, dv, hl, br;
        logic [6:0] exp;
    } vec_t;

    localparam logic [6:0] RUN   = 7'b1100000;
    localparam logic [6:0] STALL = 7'b0001000;
    localparam logic [6:0] FLUSH = 7'b1111000;

    logic [6:0]  sb[$];
    int          n_cmp = 0, n_bad = 0;
    logic [15:0] exp_stall = 16'd0;
    vec_t        tbl[9];
    vec_t        idle_v;

    function automatic vec_t mk(input logic [4:0] rs, rt, input logic u, input logic [4:0] ex_rt,
                                input logic mr, md, dv, hl, br, input logic [6:0] exp);
        vec_t v;
        v.rs = rs; v.rt = rt; v.uses_rt = u; v.ex_rt = ex_rt; v.mem_rd = mr;
        v.md = md; v.dv = dv; v.hl = hl; v.br = br; v.exp = exp;
        return v;
    endfunction

    task automatic set_in(input vec_t v);
        ID_regRs = v.rs; ID_regRt = v.rt; ID_usesRt = v.uses_rt; ID_EX_regRt = v.ex_rt;
        ID_EX_memRead = v.mem_rd; ID_isMulDiv = v.md; ID_isDiv = v.dv;
        ID_readsHiLo = v.hl; EX_branchTaken = v.br;
    endtask

    task automatic chk(input string nm, input logic [15:0] got, input logic [15:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", nm, got, exp);
        end
    endtask

    function automatic logic [6:0] outs();
        return {pcWrite, IF_ID_write, IF_ID_flush, ID_EX_flush, md_start, md_busy, md_done};
    endfunction

    // one clock cycle: drive after the rising edge, compare at the falling edge
    task automatic drive(input string nm, input vec_t v);
        logic [6:0] e;
        @(posedge clk);
        #1;
        set_in(v);
        sb.push_back(v.exp);
        @(negedge clk);
        if (sb.size() == 0) begin
            chk({nm, " scoreboard"}, 16'd0, 16'd1);
        end else begin
            e = sb.pop_front();
            chk({nm, " outs"}, 16'(outs()), 16'(e));
            chk({nm, " stall_cycles"}, stall_cycles, exp_stall);
            if (!e[6] && exp_stall != 16'hFFFF) exp_stall++;
        end
    endtask

    initial begin
        idle_v = mk(0, 0, 0, 0, 0, 0, 0, 0, 0, RUN);
        tbl[0] = mk(5, 0, 0, 5, 1, 0, 0, 0, 0, STALL);
        tbl[1] = mk(0, 0, 1, 0, 1, 0, 0, 0, 0, RUN);
        tbl[2] = mk(1, 5, 0, 5, 1, 0, 0, 0, 0, RUN);
        tbl[3] = mk(1, 5, 1, 5, 1, 0, 0, 0, 0, STALL);
        tbl[4] = mk(5, 5, 1, 5, 0, 0, 0, 0, 0, RUN);
        tbl[5] = mk(5, 0, 0, 5, 1, 0, 0, 0, 1, FLUSH);
        tbl[6] = mk(0, 0, 0, 0, 0, 0, 0, 0, 1, FLUSH);
        tbl[7] = mk(0, 0, 0, 0, 0, 1, 1, 0, 1, FLUSH);
        tbl[8] = mk(0, 0, 0, 0, 0, 0, 0, 1, 0, RUN);

        set_in(idle_v);
        #2;
        chk("reset outs", 16'(outs()), 16'(RUN));
        chk("reset stall_cycles", stall_cycles, 16'd0);
        #8 rst_n = 1'b1;

        foreach (tbl[i]) drive($sformatf("vec%0d", i), tbl[i]);

        drive("mul c0", mk(0, 0, 0, 0, 0, 1, 0, 0, 0, 7'b1100100));
        for (int c = 1; c <= 3; c++) drive($sformatf("mflo c%0d", c), mk(0, 0, 0, 0, 0, 0, 0, 1, 0, 7'b0001010));
        drive("mflo c4", mk(0, 0, 0, 0, 0, 0, 0, 1, 0, 7'b0001011));
        drive("mflo c5", mk(0, 0, 0, 0, 0, 0, 0, 1, 0, RUN));
        drive("mul restart", mk(0, 0, 0, 0, 0, 1, 0, 0, 0, 7'b1100100));
        for (int c = 1; c <= 3; c++) drive($sformatf("mul2 c%0d", c), mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 7'b1100010));
        drive("mul2 c4", mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 7'b1100011));

        drive("div c0", mk(0, 0, 0, 0, 0, 1, 1, 0, 0, 7'b1100100));
        drive("div c1", mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 7'b1100010));
        drive("div br c2", mk(0, 0, 0, 0, 0, 0, 0, 1, 1, 7'b1111010));
        for (int c = 3; c <= 31; c++) drive($sformatf("div c%0d", c), mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 7'b1100010));
        drive("div c32", mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 7'b1100011));
        drive("div c33", mk(0, 0, 0, 0, 0, 0, 0, 1, 0, RUN));

        drive("lu pre-reset", tbl[0]);
        drive("div2 c0", mk(0, 0, 0, 0, 0, 1, 1, 0, 0, 7'b1100100));
        for (int c = 1; c <= 16; c++) drive($sformatf("div2 c%0d", c), mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 7'b1100010));
        #1 rst_n = 1'b0;
        #1;
        chk("async rst md_busy", 16'(md_busy), 16'd0);
        chk("async rst stall_cycles", stall_cycles, 16'd0);
        exp_stall = 16'd0;
        @(negedge clk);
        chk("rst held outs", 16'(outs()), 16'(RUN));
        chk("rst held stall_cycles", stall_cycles, 16'd0);
        rst_n = 1'b1;
        drive("post-reset idle", idle_v);
        drive("post-reset lu", tbl[0]);
        drive("post-reset check", idle_v);

        @(posedge clk);
        #1 set_in(tbl[0]);
        repeat (65540) @(posedge clk);
        @(negedge clk);
        chk("saturate", stall_cycles, 16'hFFFF);
        exp_stall = 16'hFFFF;
        drive("saturate hold", tbl[0]);
        drive("saturate final", idle_v);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule

// File: doc/hazard_ctrl.md
HAZARD_CTRL -- requirements
Module: hazard_ctrl

Interface
REQ-001 Parameter MUL_LAT, default 4: cycles a multiply occupies the HI/LO unit, legal range 1..63.
REQ-002 Parameter DIV_LAT, default 32: cycles a divide occupies the HI/LO unit, legal range 1..63.
REQ-003 clk  input  1  single clock; all state updates on the rising edge.
REQ-004 rst_n  input  1  asynchronous, active-low reset.
REQ-005 ID_regRs  input  5  rs field of the instruction in ID.
REQ-006 ID_regRt  input  5  rt field of the instruction in ID.
REQ-007 ID_usesRt  input  1  ID instruction reads rt as a source.
REQ-008 ID_EX_regRt  input  5  destination rt of the instruction in EX.
REQ-009 ID_EX_memRead  input  1  instruction in EX is a load.
REQ-010 ID_isMulDiv  input  1  ID instruction is mult/multu/div/divu.
REQ-011 ID_isDiv  input  1  qualifies ID_isMulDiv: 1 = divide, 0 = multiply.
REQ-012 ID_readsHiLo  input  1  ID instruction is mfhi/mflo/mthi/mtlo.
REQ-013 EX_branchTaken  input  1  branch/jump in EX resolved taken.
REQ-014 pcWrite  output  1  1 = PC advances.
REQ-015 IF_ID_write  output  1  1 = IF/ID register loads.
REQ-016 IF_ID_flush  output  1  1 = IF/ID loads a bubble.
REQ-017 ID_EX_flush  output  1  1 = ID/EX loads a bubble (all control bits zero).
REQ-018 md_start  output  1  one-cycle pulse launching the HI/LO unit.
REQ-019 md_busy  output  1  HI/LO unit is occupied.
REQ-020 md_done  output  1  one-cycle pulse in the last busy cycle.
REQ-021 stall_cycles  output  16  saturating count of stall cycles.

Function
REQ-022 Load-use hazard (LU) SHALL be: ID_EX_memRead && ID_EX_regRt!=0 && (ID_EX_regRt==ID_regRs || (ID_usesRt && ID_EX_regRt==ID_regRt)).
REQ-023 HI/LO hazard (MH) SHALL be: md_busy && (ID_isMulDiv || ID_readsHiLo).
REQ-024 Stall (ST) SHALL be (LU || MH) && !EX_branchTaken.
REQ-025 When ST: pcWrite=0, IF_ID_write=0, ID_EX_flush=1, IF_ID_flush=0 (combinational, same cycle).
REQ-026 When EX_branchTaken: pcWrite=1, IF_ID_write=1, IF_ID_flush=1, ID_EX_flush=1, regardless of LU/MH; the branch has priority.
REQ-027 Otherwise: pcWrite=1, IF_ID_write=1, IF_ID_flush=0, ID_EX_flush=0.
REQ-028 md_start SHALL be 1 exactly when ID_isMulDiv && !ST && !EX_branchTaken; it is combinational.
REQ-029 6-bit counter md_cnt: on a clock edge with md_start, load DIV_LAT if ID_isDiv, else MUL_LAT; otherwise, if nonzero, decrement by 1.
REQ-030 md_busy = (md_cnt != 0); md_done = (md_cnt == 1).
REQ-031 After md_start in cycle t, md_busy is 1 in cycles t+1 .. t+LAT and 0 in cycle t+LAT+1.
REQ-032 A dependent mf*/mul/div held in ID issues in the cycle md_busy falls to 0; a new mul/div may start in that same cycle.
REQ-033 A taken branch never cancels an in-flight md_cnt; it only suppresses a start from the wrong-path ID instruction.
REQ-034 LU and MH together SHALL produce one stall per cycle and one stall_cycles increment per cycle.
REQ-035 stall_cycles increments on each edge where ST=1 and saturates at 16'hFFFF; it does not wrap.
REQ-036 Only md_cnt and stall_cycles are state; all other outputs are combinational from the inputs and md_cnt.

Reset
REQ-037 rst_n=0 SHALL clear md_cnt and stall_cycles asynchronously, without waiting for clk, including mid-operation.
REQ-038 While reset is held and inputs are idle, outputs SHALL be: pcWrite=1, IF_ID_write=1, both flushes 0, md_busy=0, md_done=0, md_start=0, stall_cycles=0.
REQ-039 On reset release, the first edge behaves as in RUN with md_cnt=0.

Verification
REQ-040 Load-use: ID_EX_memRead=1, ID_EX_regRt=5, ID_regRs=5 -> one cycle with pcWrite=0 and ID_EX_flush=1; stall_cycles=1. With ID_EX_regRt=0, or ID_regRt=5 and ID_usesRt=0 -> no stall.
REQ-041 Multiply then mflo: mult issued in cycle 0 with MUL_LAT=4 -> md_start=1 in cycle 0; mflo in cycle 1 stalls cycles 1-4; md_done=1 in cycle 4; mflo issues in cycle 5; stall_cycles=4.
REQ-042 Divide followed by a taken branch in cycle 2 -> md_cnt keeps counting and md_busy stays 1 through cycle 32; IF_ID_flush=ID_EX_flush=1 in cycle 2; a mflo in ID during cycle 2 is not stalled.
REQ-043 Branch in EX with div in ID -> md_start=0, md_busy stays 0.
REQ-044 Reset mid-divide: rst_n asserted at md_cnt=17 -> md_busy=0 immediately and stall_cycles=0.
REQ-045 Saturation: force 65540 stall cycles -> stall_cycles holds 16'hFFFF.
